zapper_frontend: RTL and testbench
==================================

# zapper_frontend

Light-gun front end that produces the `trigger` and `detect` inputs consumed by the VGA pattern generator. It conditions the raw zapper trigger into a debounced level. It tracks the same black-frame/white-frame shot sequence the pattern generator runs. During the white frame it asserts `detect` only if the photodiode saw the white target box and was dark during the preceding black frame, which rejects aiming at a lamp. It sits between the board pins and the pattern generator, in the 25 MHz pixel-clock domain.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: cycles the synchronized trigger must be stable before `trigger` changes (10 ms at 25 MHz).
- `LIGHT_MIN`, default 64: active-video light samples in the white frame required for a hit.
- `DARK_MAX`, default 16: black-frame light samples above which the shot is rejected as cheating.
- `CNT_W`, default 17: light-counter width; counters saturate at all-ones.

Ports:
- `clk`  in  1  pixel clock; single clock domain.
- `rst`  in  1  reset, synchronous and active-high.
- `trigger_n_raw`  in  1  zapper trigger pin; asynchronous, active-low.
- `light_n_raw`  in  1  zapper photodiode pin; asynchronous, active-low (low = light seen).
- `valid`  in  1  active-video qualifier from the VGA timing block.
- `frame_tick`  in  1  one-cycle pulse at the start of vertical blanking. The pattern generator advances its screen state on this same event.
- `trigger`  out  1  debounced trigger level, active-high.
- `detect`  out  1  hit indication, valid only during the white frame.
- `shot_done`  out  1  one-cycle pulse when a shot sequence ends.
- `shot_hit`  out  1  result of the last shot; valid while `shot_done` is high and held until the next `shot_done`.

## Operation
- Both raw pins pass through 2-flop synchronizers. The trigger is inverted and then debounced. Light is inverted to `light_s`; it is not debounced.
- Debounce uses a counter that resets whenever the synchronized trigger equals `trigger`. When the counter reaches `DEBOUNCE_CYCLES-1`, `trigger` toggles and the counter clears.
- Shot FSM states are IDLE, BLACK, WHITE and HELD. All transitions happen only in the cycle where `frame_tick`=1.
  - IDLE→BLACK when `trigger`=1.
  - BLACK→WHITE unconditionally. On this tick, `cheat` latches (`dark_cnt` > `DARK_MAX`) and `white_cnt` clears.
  - WHITE→HELD unconditionally. This tick emits `shot_done`=1, with `shot_hit` = `detect` as sampled in that cycle.
  - HELD→IDLE when `trigger`=0; otherwise it stays in HELD.
- On the IDLE→BLACK tick, `dark_cnt` clears.
- In BLACK, `dark_cnt` increments on each cycle with `valid & light_s`.
- In WHITE, `white_cnt` increments on each cycle with `valid & light_s`.
- Light samples with `valid`=0 are ignored in all states.
- Both counters saturate: there is no wrap-around at all-ones.
- `detect` is registered. In WHITE, `detect` <= (`white_cnt` >= `LIGHT_MIN`) & !`cheat`. In every other state it is 0.
  - Once set, `detect` stays 1 until the WHITE→HELD tick.
  - The 0 written on that tick is visible in the following cycle, so the pattern generator sampling on the tick sees `detect`=1.
- If the trigger is released during BLACK or WHITE, the sequence still completes; HELD then exits on the next tick.
- Tick handling when a counter increment and a transition fall in the same cycle:
  - IDLE→BLACK tick: the clear wins.
  - BLACK→WHITE tick: `cheat` uses `dark_cnt` before any increment in that cycle.
  - WHITE→HELD tick: `shot_hit` uses the registered `detect`.
- `rst` mid-sequence returns the FSM to IDLE immediately. It also clears the counters, `cheat`, `detect`, `shot_done` and `shot_hit`, and resets `trigger` to 0. The synchronizer flops reset to the idle level (1 for the active-low raw pins).

## Timing
- Reset values: `trigger`=0, `detect`=0, `shot_done`=0, `shot_hit`=0, FSM in IDLE, both counters 0.
- Trigger latency from a stable pin change to `trigger` is 2 sync cycles plus `DEBOUNCE_CYCLES`, ±1 cycle.
- Light latency from the pin to a counter increment is 3 cycles.
- `white_cnt` reaching `LIGHT_MIN` sets `detect` 1 cycle later.
- The shot takes 3 ticks from the press-qualified tick to `shot_done`.
- `shot_done` is exactly one cycle wide, coincident with the WHITE→HELD tick.

## Structure
- Shared package `duck_hunt_pkg`:
  - `gun_state_t` (IDLE, BLACK, WHITE, HELD), to be shared with the pattern generator's screen enum.
  - `SCREEN_WIDTH`=640, `SCREEN_HEIGHT`=480.
  - Default `LIGHT_MIN`/`DARK_MAX`.
- One sub-module, `debouncer`, containing the synchronizer plus the stability counter, parameterized by `DEBOUNCE_CYCLES`. The light path reuses only its 2-flop synchronizer.

## Test plan
- Hold `trigger_n_raw` low for 300000 cycles with 5 bounces in the first 1000 → `trigger` rises exactly once, `DEBOUNCE_CYCLES`+2 (±1) cycles after the last bounce.
- Press; light dark for the black frame; white frame with 200 valid light cycles → `detect`=1 from cycle LIGHT_MIN+4 of the light burst until the cycle after the tick; `shot_done`=1 with `shot_hit`=1.
- Same as the hit scenario, but 100 light cycles in the black frame → `cheat`=1, `detect` stays 0, `shot_hit`=0.
- White frame with 50 light cycles (< 64), plus 500 light cycles with `valid`=0 → `detect` stays 0, `shot_hit`=0.
- Keep the trigger held for 5 frames after a shot → FSM stays in HELD, no second `shot_done`; release → IDLE on the next tick.
- Assert `rst` for 1 cycle mid-WHITE with `detect`=1 → next cycle all outputs are 0 and FSM is IDLE; a new press starts a clean sequence.

Source files
------------

// File: rtl/duck_hunt_pkg.sv
// Shared Duck Hunt types and constants used by the zapper front end and the
// VGA pattern generator, so both step through the same screen sequence.
package duck_hunt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLACK = 2'd1,
    WHITE = 2'd2,
    HELD  = 2'd3
  } gun_state_t;

  localparam int SCREEN_WIDTH            = 640;
  localparam int SCREEN_HEIGHT           = 480;
  localparam int LIGHT_MIN_DEFAULT       = 64;
  localparam int DARK_MAX_DEFAULT        = 16;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 250000;

endpackage

// File: rtl/zapper_frontend_debouncer.sv
// Two-flop pin synchronizer, plus the trigger debouncer that builds on it.
// The light path instantiates sync2 on its own because the photodiode must not be debounced.
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

module debouncer
  import duck_hunt_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_n,
  output logic level
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          raw_s;
  logic          pressed;
  logic [CW-1:0] cnt;

  // Idle level of the active-low pin is 1, so reset never looks like a press.
  sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (raw_n),
    .q   (raw_s)
  );

  assign pressed = !raw_s;

  // Any sample that agrees with the current level restarts the stability window.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (pressed == level) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      level <= !level;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/zapper_frontend.sv
// Zapper light-gun front end: debounced trigger plus black/white shot tracking
// that raises detect only for a real hit on the white box, never for a lamp.
module zapper_frontend
  import duck_hunt_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int LIGHT_MIN       = LIGHT_MIN_DEFAULT,
  parameter int DARK_MAX        = DARK_MAX_DEFAULT,
  parameter int CNT_W           = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trigger_n_raw,
  input  logic       light_n_raw,
  input  logic       valid,
  input  logic       frame_tick,
  output logic       trigger,
  output logic       detect,
  output logic       shot_done,
  output logic       shot_hit,
  output gun_state_t state
);

  localparam logic [CNT_W-1:0] LIGHT_MIN_C = CNT_W'(LIGHT_MIN);
  localparam logic [CNT_W-1:0] DARK_MAX_C  = CNT_W'(DARK_MAX);

  gun_state_t       state_next;
  logic             light_n_s;
  logic             light_s;
  logic             lit;
  logic [CNT_W-1:0] dark_cnt;
  logic [CNT_W-1:0] white_cnt;
  logic             cheat;
  logic             detect_next;
  logic             hit_held;

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_trigger_db (
    .clk   (clk),
    .rst   (rst),
    .raw_n (trigger_n_raw),
    .level (trigger)
  );

  sync2 #(.RESET_VAL(1'b1)) u_light_sync (
    .clk (clk),
    .rst (rst),
    .d   (light_n_raw),
    .q   (light_n_s)
  );

  assign light_s = !light_n_s;
  // Light only counts while the beam is drawing visible pixels.
  assign lit     = valid & light_s;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    shot_done   = 1'b0;
    detect_next = 1'b0;
    case (state)
      IDLE:  if (frame_tick && trigger) state_next = BLACK;
      BLACK: if (frame_tick) state_next = WHITE;
      WHITE: begin
        if (frame_tick) begin
          state_next = HELD;
          shot_done  = 1'b1;
        end else begin
          detect_next = (white_cnt >= LIGHT_MIN_C) && !cheat;
        end
      end
      HELD:    if (frame_tick && !trigger) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // On the closing tick the registered detect is reported, matching what the
  // pattern generator samples on that same edge.
  assign shot_hit = shot_done ? detect : hit_held;

  always_ff @(posedge clk) begin
    if (rst) begin
      dark_cnt  <= '0;
      white_cnt <= '0;
      cheat     <= 1'b0;
      detect    <= 1'b0;
      hit_held  <= 1'b0;
    end else begin
      detect <= detect_next;
      if (shot_done) hit_held <= detect;
      case (state)
        IDLE: begin
          if (state_next == BLACK) dark_cnt <= '0;
        end
        BLACK: begin
          if (lit && (dark_cnt != '1)) dark_cnt <= dark_cnt + CNT_W'(1);
          if (frame_tick) begin
            cheat     <= dark_cnt > DARK_MAX_C;
            white_cnt <= '0;
          end
        end
        WHITE: begin
          if (lit && (white_cnt != '1)) white_cnt <= white_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_zapper_frontend.sv
// Directed bench for zapper_frontend: debounce latency, hit, cheat, low light,
// held trigger, counter saturation and mid-shot reset.
module tb_zapper_frontend;
  import duck_hunt_pkg::*;

  localparam int D    = 100;
  localparam int LMIN = 64;
  localparam int DMAX = 16;
  localparam int CW   = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       trigger_n_raw;
  logic       light_n_raw;
  logic       valid;
  logic       frame_tick;
  logic       trigger;
  logic       detect;
  logic       shot_done;
  logic       shot_hit;
  gun_state_t state;

  int         errors = 0;
  int         checks = 0;
  logic [0:0] exp_q[$];
  logic [0:0] mon_exp;

  // Clock and reset
  always #20 clk = ~clk;

  zapper_frontend #(
    .DEBOUNCE_CYCLES (D),
    .LIGHT_MIN       (LMIN),
    .DARK_MAX        (DMAX),
    .CNT_W           (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .trigger_n_raw (trigger_n_raw),
    .light_n_raw   (light_n_raw),
    .valid         (valid),
    .frame_tick    (frame_tick),
    .trigger       (trigger),
    .detect        (detect),
    .shot_done     (shot_done),
    .shot_hit      (shot_hit),
    .state         (state)
  );

  // Scoreboard monitor: every shot_done pops one expected shot_hit.
  always @(negedge clk) begin
    if (shot_done === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL shot_done_unexpected: got shot_done with shot_hit=%0d, required no shot_done", shot_hit);
      end else begin
        mon_exp = exp_q.pop_front();
        if (shot_hit !== mon_exp) begin
          errors++;
          $display("FAIL shot_hit: got %0d required %0d", shot_hit, mon_exp);
        end
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic press(input string nm);
    trigger_n_raw = 1'b0;
    repeat (D + 4) step();
    check(nm, trigger, 1);
  endtask

  task automatic release_to_idle(input string nm);
    trigger_n_raw = 1'b1;
    repeat (D + 4) step();
    check({nm, "_trigger_low"}, trigger, 0);
    tick();
    check({nm, "_idle"}, state, IDLE);
  endtask

  task automatic start_shot(input string nm);
    tick();
    check({nm, "_black"}, state, BLACK);
  endtask

  task automatic to_white(input string nm);
    tick();
    check({nm, "_white"}, state, WHITE);
  endtask

  // n_lit valid light cycles followed by a dark tail that is still valid video.
  task automatic black_frame(input int n_lit);
    for (int i = 0; i < n_lit + 20; i++) begin
      light_n_raw = (i < n_lit) ? 1'b0 : 1'b1;
      valid       = 1'b1;
      step();
    end
    valid = 1'b0;
  endtask

  // detect is checked every cycle; det_from=0 means it must stay low.
  task automatic white_frame(input string nm, input int n_valid, input int n_invalid,
                             input int tail, input int det_from);
    for (int i = 1; i <= n_valid + n_invalid + tail; i++) begin
      if (i <= n_valid) begin
        light_n_raw = 1'b0;
        valid       = 1'b1;
      end else if (i <= n_valid + n_invalid) begin
        light_n_raw = 1'b0;
        valid       = 1'b0;
      end else begin
        light_n_raw = 1'b1;
        valid       = 1'b0;
      end
      check(nm, detect, (det_from > 0 && i >= det_from) ? 1 : 0);
      step();
    end
  endtask

  task automatic finish_shot(input string nm, input logic exp_hit, input logic exp_det);
    exp_q.push_back(exp_hit);
    check({nm, "_detect_at_tick"}, detect, exp_det);
    tick();
    check({nm, "_shot_seen"}, exp_q.size(), 0);
    check({nm, "_held"}, state, HELD);
    check({nm, "_detect_after_tick"}, detect, 0);
    check({nm, "_hit_held"}, shot_hit, exp_hit);
  endtask

  // Stimulus
  initial begin
    int  n;
    bit  early;
    bit  dropped;

    rst           = 1'b1;
    trigger_n_raw = 1'b1;
    light_n_raw   = 1'b1;
    valid         = 1'b0;
    frame_tick    = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    check("rst_trigger", trigger, 0);
    check("rst_detect", detect, 0);
    check("rst_shot_done", shot_done, 0);
    check("rst_shot_hit", shot_hit, 0);
    check("rst_state", state, IDLE);
    tick();
    check("idle_tick_no_trigger", state, IDLE);

    // Bouncy press: five short lows, then a steady low.
    early = 1'b0;
    for (int b = 0; b < 5; b++) begin
      trigger_n_raw = 1'b0;
      for (int c = 0; c < 10; c++) begin step(); early |= trigger; end
      trigger_n_raw = 1'b1;
      for (int c = 0; c < 5; c++) begin step(); early |= trigger; end
    end
    check("bounce_no_early_rise", early, 0);
    trigger_n_raw = 1'b0;
    n = 0;
    while (trigger !== 1'b1 && n < 3 * D) begin
      step();
      n++;
    end
    checks++;
    if (n < D + 1 || n > D + 3) begin
      errors++;
      $display("FAIL bounce_latency: got %0d cycles required %0d +/-1", n, D + 2);
    end
    dropped = 1'b0;
    for (int c = 0; c < 300; c++) begin step(); dropped |= !trigger; end
    check("bounce_stays_high", dropped, 0);

    // Too little light in white, lots of light outside active video.
    start_shot("low");
    black_frame(0);
    to_white("low");
    white_frame("low_detect", 50, 500, 10, 0);
    finish_shot("low", 1'b0, 1'b0);
    release_to_idle("low");

    // Lamp aiming: light in black frame; 270 counts also proves dark_cnt saturates.
    press("cheat_press");
    start_shot("cheat");
    black_frame(270);
    to_white("cheat");
    white_frame("cheat_detect", 200, 0, 10, 0);
    finish_shot("cheat", 1'b0, 1'b0);
    release_to_idle("cheat");

    // Clean hit with exactly DARK_MAX black-frame samples, then trigger held 5 frames.
    press("hit_press");
    start_shot("hit");
    black_frame(DMAX);
    to_white("hit");
    white_frame("hit_detect", 200, 0, 20, LMIN + 4);
    finish_shot("hit", 1'b1, 1'b1);
    for (int f = 0; f < 5; f++) begin
      tick();
      check("hold_state", state, HELD);
      check("hold_hit", shot_hit, 1);
    end
    release_to_idle("hit");
    check("hit_result_kept", shot_hit, 1);

    // Reset in the middle of a white frame with detect already high.
    press("rst_press");
    start_shot("pre_rst");
    black_frame(0);
    to_white("pre_rst");
    white_frame("pre_rst_detect", 100, 0, 0, LMIN + 4);
    check("pre_rst_detect_high", detect, 1);
    light_n_raw = 1'b1;
    valid       = 1'b0;
    rst         = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_trigger", trigger, 0);
    check("mid_rst_detect", detect, 0);
    check("mid_rst_shot_done", shot_done, 0);
    check("mid_rst_shot_hit", shot_hit, 0);
    check("mid_rst_state", state, IDLE);

    // Pin still held: trigger returns and a fresh shot with a saturating white count.
    repeat (D + 4) step();
    check("post_rst_trigger", trigger, 1);
    start_shot("post_rst");
    black_frame(0);
    to_white("post_rst");
    white_frame("post_rst_detect", 300, 0, 10, LMIN + 4);
    finish_shot("post_rst", 1'b1, 1'b1);
    release_to_idle("post_rst");

    repeat (5) step();
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
